// File: rtl/det_share_arb.sv
// ============================================================================
//  Module      : det_share_arb
//  Description : Shares one external serial "done" detector between N word
//                requesters. A round-robin arbiter grants one requester,
//                clears the detector, shifts the granted word MSB-first on
//                det_sin, counts det_done hits over a WIDTH-cycle window
//                delayed by DONE_LAT, and returns the count tagged with the
//                requester index.
//                Optional build macro DET_SHARE_FIRST_POS_EN adds output
//                res_first (window index of the first hit, WIDTH if none).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module det_share_arb #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int DONE_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 req_valid,
    output logic [N-1:0]                 req_ready,
    input  logic [N*WIDTH-1:0]           req_data,
    output logic                         det_sin,
    output logic                         det_rst,
    input  logic                         det_done,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(N)-1:0]         res_id,
    output logic [$clog2(WIDTH+1)-1:0]   res_hits,
    output logic                         busy
`ifdef DET_SHARE_FIRST_POS_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0]   res_first
`endif
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_IW = $clog2(N);
    localparam int c_HW = $clog2(WIDTH + 1);
    // Frame timeline counter spans SHIFT and DRAIN: 0 .. WIDTH+DONE_LAT-1
    localparam int c_TW = $clog2(WIDTH + DONE_LAT + 1);

    localparam logic [c_TW-1:0] c_LAST_BIT  = c_TW'(WIDTH - 1);
    localparam logic [c_TW-1:0] c_LAST_T    = c_TW'(WIDTH + DONE_LAT - 1);
    localparam logic [c_TW-1:0] c_WIN_START = c_TW'(DONE_LAT);
    localparam logic [c_IW-1:0] c_PTR_RST   = c_IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_SHIFT  = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [c_IW-1:0]    r_ptr;      // last granted requester
    logic [c_IW-1:0]    r_id;       // requester owning the current frame
    logic [WIDTH-1:0]   r_word;     // remaining bits, MSB is next to send
    logic [c_TW-1:0]    r_tcnt;     // cycle index since first SHIFT cycle
    logic [c_HW-1:0]    r_hits;     // hits counted so far in this frame

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_gnt_found;
    logic [c_IW-1:0]    w_gnt_idx;
    logic [c_IW-1:0]    w_cand;
    logic [WIDTH-1:0]   w_gnt_word;
    logic               w_in_win;
    logic               w_hit;
    logic [c_HW-1:0]    w_hits_next;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = c_IW'((int'(r_ptr) + i) % N);
            if (!w_gnt_found && req_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    // Select the granted requester's word without a variable part-select
    always_comb begin
        w_gnt_word = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == c_IW'(i)) begin
                w_gnt_word = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot accept only while idle; held low while reset is asserted
    always_comb begin
        req_ready = '0;
        if (rst && (r_state == S_IDLE) && w_gnt_found) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Count window: SHIFT cycle k pairs with timeline cycle k+DONE_LAT
    always_comb begin
        w_in_win    = ((r_state == S_SHIFT) || (r_state == S_DRAIN)) &&
                      (r_tcnt >= c_WIN_START);
        w_hit       = w_in_win && det_done;
        w_hits_next = r_hits + {{(c_HW-1){1'b0}}, w_hit};
    end

`ifdef DET_SHARE_FIRST_POS_EN
    localparam logic [c_HW-1:0] c_NO_HIT = c_HW'(WIDTH);

    logic [c_HW-1:0]    r_first;
    logic [c_HW-1:0]    w_k;
    logic [c_HW-1:0]    w_first_next;

    // Window index of the current sample and first-hit capture
    always_comb begin
        w_k          = c_HW'(r_tcnt - c_WIN_START);
        w_first_next = (w_hit && (r_first == c_NO_HIT)) ? w_k : r_first;
    end
`endif

    // ------------------------------------------------------------------------
    // Frame sequencer with registered detector and result outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= c_PTR_RST;
            r_id      <= '0;
            r_word    <= '0;
            r_tcnt    <= '0;
            r_hits    <= '0;
            det_sin   <= 1'b0;
            det_rst   <= 1'b1;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_hits  <= '0;
            busy      <= 1'b0;
`ifdef DET_SHARE_FIRST_POS_EN
            r_first   <= c_NO_HIT;
            res_first <= c_NO_HIT;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    det_rst <= 1'b1;
                    det_sin <= 1'b0;
                    if (w_gnt_found) begin
                        r_ptr   <= w_gnt_idx;
                        r_id    <= w_gnt_idx;
                        r_word  <= w_gnt_word;
                        busy    <= 1'b1;
                        r_state <= S_CLR;
                    end
                end

                S_CLR: begin
                    // Detector is held in clear this cycle; arm the first bit
                    r_tcnt  <= '0;
                    r_hits  <= '0;
`ifdef DET_SHARE_FIRST_POS_EN
                    r_first <= c_NO_HIT;
`endif
                    det_rst <= 1'b0;
                    det_sin <= r_word[WIDTH-1];
                    r_word  <= {r_word[WIDTH-2:0], 1'b0};
                    r_state <= S_SHIFT;
                end

                S_SHIFT: begin
                    r_tcnt  <= r_tcnt + 1'b1;
                    r_hits  <= w_hits_next;
`ifdef DET_SHARE_FIRST_POS_EN
                    r_first <= w_first_next;
`endif
                    if (r_tcnt == c_LAST_BIT) begin
                        det_sin <= 1'b0;
                        if (DONE_LAT == 0) begin
                            // No pipeline to drain: the window closes now
                            det_rst   <= 1'b1;
                            res_valid <= 1'b1;
                            res_id    <= r_id;
                            res_hits  <= w_hits_next;
`ifdef DET_SHARE_FIRST_POS_EN
                            res_first <= w_first_next;
`endif
                            r_state   <= S_REPORT;
                        end else begin
                            r_state   <= S_DRAIN;
                        end
                    end else begin
                        det_sin <= r_word[WIDTH-1];
                        r_word  <= {r_word[WIDTH-2:0], 1'b0};
                    end
                end

                S_DRAIN: begin
                    // Collect the detector responses still in flight
                    det_sin <= 1'b0;
                    r_tcnt  <= r_tcnt + 1'b1;
                    r_hits  <= w_hits_next;
`ifdef DET_SHARE_FIRST_POS_EN
                    r_first <= w_first_next;
`endif
                    if (r_tcnt == c_LAST_T) begin
                        det_rst   <= 1'b1;
                        res_valid <= 1'b1;
                        res_id    <= r_id;
                        res_hits  <= w_hits_next;
`ifdef DET_SHARE_FIRST_POS_EN
                        res_first <= w_first_next;
`endif
                        r_state   <= S_REPORT;
                    end
                end

                S_REPORT: begin
                    // Result held until accepted; no grant in the accept cycle
                    det_rst <= 1'b1;
                    det_sin <= 1'b0;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    det_rst   <= 1'b1;
                    det_sin   <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/det_share_arb.md
Name: det_share_arb

Overview:
- Shares one external serial sequence detector (ports sin/rst in, done out) between N requesters.
- Each requester offers a WIDTH-bit word. The block picks one requester round-robin, clears the detector, and shifts the word MSB-first into the detector.
- It counts detector hits during the shift, then returns the hit count tagged with the requester ID.
- Sits between parallel-word producers and the shared detector instance.

Parameters:
- N, 4, number of requesters; N >= 2 is required.
- WIDTH, 8, bits per word; WIDTH >= 2.
- DONE_LAT, 1, cycles from a bit driven on sin to its effect appearing on det_done. Range 0..4.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  N  per-requester word valid.
- req_ready  output  N  one-hot accept pulse.
- req_data  input  N*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
- det_sin  output  1  serial bit to the detector sin.
- det_rst  output  1  active-high clear to the detector rst.
- det_done  input  1  detector done output.
- res_valid  output  1  result valid; held until accepted.
- res_ready  input  1  result accept.
- res_id  output  $clog2(N)  requester index of the result.
- res_hits  output  $clog2(WIDTH+1)  number of det_done=1 samples in the count window.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous) forces, immediately:
  - state=IDLE, req_ready=0, det_sin=0, det_rst=1, res_valid=0, res_id=0, res_hits=0, busy=0.
  - RR pointer = N-1, so requester 0 wins first.
  - Reset mid-frame abandons the frame; no result is produced.
- IDLE:
  - det_rst=1.
  - If any req_valid, grant the first asserted index searching ptr+1, ptr+2, ... with wrap mod N.
  - Same cycle: req_ready[g]=1 (combinational from req_valid and state), latch req_data word g, ptr<=g, id<=g, go CLR.
  - Requesters must hold req_valid/req_data until req_ready; a drop before grant is legal and simply not granted.
- CLR:
  - One cycle, det_rst=1, det_sin=0.
  - Clear the hit counter, bit counter and window counter.
  - Go SHIFT.
- SHIFT:
  - WIDTH cycles, det_rst=0.
  - Cycle k (0..WIDTH-1) drives det_sin = word[WIDTH-1-k].
  - After the last bit, go DRAIN if DONE_LAT>0, else REPORT.
- DRAIN:
  - DONE_LAT cycles, det_sin=0, det_rst=0.
  - Then go REPORT.
- Count window:
  - Exactly WIDTH cycles: SHIFT cycle k pairs with the cycle DONE_LAT later.
  - Hits increment when det_done=1 inside the window.
  - det_done outside the window (IDLE, CLR, the first DONE_LAT SHIFT cycles) is ignored.
  - The counter cannot overflow; its max is WIDTH.
- REPORT:
  - res_valid=1; res_id/res_hits stable while res_valid=1.
  - det_rst=1, det_sin=0.
  - When res_valid&res_ready, go IDLE. No new grant is issued in the same cycle.
- Latency:
  - Accept at cycle 0; res_valid rises at cycle WIDTH+DONE_LAT+2.
  - With res_ready tied 1, throughput is one word per WIDTH+DONE_LAT+3 cycles.
- Fairness: a continuously requesting input waits at most N-1 frames.
- req_ready is zero outside IDLE.

Optional Feature:
- Macro: DET_SHARE_FIRST_POS_EN.
- Defined:
  - Adds output res_first [$clog2(WIDTH+1)-1:0], the window index k (0..WIDTH-1) of the first hit in the frame.
  - res_first=WIDTH if there are no hits.
  - Reset value WIDTH; held with res_valid.
- Undefined: port absent; no extra logic.

Test Plan:
- Bench uses an overlapping "1101" Moore detector model, DONE_LAT=1, N=4, WIDTH=8, res_ready=1.
- Single request: req_valid=4'b0001, word 8'hDA (1101_1010).
  - req_ready[0] at cycle 0; det_rst pulse at cycle 1; sin 1,1,0,1,1,0,1,0 at cycles 2-9.
  - res_valid at cycle 11 with res_id=0, res_hits=2.
  - With DET_SHARE_FIRST_POS_EN defined: res_first=3.
- Zero word: req 2 sends 8'h00 -> res_id=2, res_hits=0 (res_first=8).
- Round-robin: all four req_valid held high with words 8'hDA, 8'hDB, 8'h0D, 8'hFF.
  - Grants in order 0,1,2,3,0.
  - Hits 2,2,1,0.
  - Frames spaced 12 cycles.
- Backpressure: res_ready=0 for 5 cycles during REPORT.
  - res_valid/res_id/res_hits are held stable.
  - req_ready stays 0 and no new grant is made until the cycle after the handshake.
- Reset mid-frame: rst low during SHIFT bit 4.
  - Immediately: det_rst=1, busy=0, res_valid=0.
  - After release, requester 0 wins first; no stale result is produced.
- Window edge: force det_done=1 during CLR and the first SHIFT cycle, with word 8'h00 -> res_hits=0.
